adv_config_sequencer: RTL and testbench

ADV_CONFIG_SEQUENCER -- requirements
Module: adv_config_sequencer

---
 rtl/adv_config_sequencer.sv | 161 ++++++++++++++++
 tb/tb_adv_config_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adv_config_sequencer.sv
// ADV7513 register-table sequencer: walks a {reg,data} ROM and issues one I2C write
// per entry, with per-entry retry, write timeout, inter-write gap and HPD-triggered reruns.
module adv_config_sequencer #(
  parameter logic [7:0] DEV_ADDR    = 8'h72,
  parameter int         NUM_ENTRIES = 32,
  parameter int         RETRY_MAX   = 3,
  parameter int         GAP_CYCLES  = 4,
  parameter int         TIMEOUT     = 4096
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic        Start,
  input  logic        HPD,
  output logic [7:0]  Rom_Index,
  input  logic [15:0] Rom_Data,
  output logic        I2C_Req,
  output logic [7:0]  I2C_Dev,
  output logic [7:0]  I2C_Reg,
  output logic [7:0]  I2C_Data,
  input  logic        I2C_Done,
  input  logic        I2C_Nack,
  output logic        Busy,
  output logic        Done,
  output logic        Error,
  output logic [7:0]  Fail_Index
);

  localparam int IDX_W = $clog2(NUM_ENTRIES + 1);
  localparam int RTY_W = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_ISSUE, S_WAIT, S_GAP, S_DONE, S_ERROR
  } state_t;

  state_t           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;
  logic [RTY_W-1:0] rty_q;
  logic [GAP_W-1:0] gap_q;
  logic [TO_W-1:0]  to_q;
  logic             adv_q;
  logic             pend_q;
  logic             start_q;
  logic             hpd_s1_q, hpd_s2_q, hpd_s3_q;
  logic [7:0]       rom_idx_q, dev_q, reg_q, dat_q, fail_q;
  logic             req_q;
  logic             trig, busy, wait_ok, wait_fail;

  assign trig  = (Start & ~start_q) | (hpd_s2_q & ~hpd_s3_q);
  assign busy  = !(state_q inside {S_IDLE, S_DONE, S_ERROR});
  assign idx_d = idx_q + IDX_W'(1);
  // A Done pulse takes priority over a timeout landing in the same cycle.
  assign wait_ok   = I2C_Done & ~I2C_Nack;
  assign wait_fail = (I2C_Done & I2C_Nack) | (~I2C_Done & (to_q == TO_W'(TIMEOUT - 1)));

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      rty_q     <= '0;
      gap_q     <= '0;
      to_q      <= '0;
      adv_q     <= 1'b0;
      pend_q    <= 1'b0;
      start_q   <= 1'b0;
      hpd_s1_q  <= 1'b0;
      hpd_s2_q  <= 1'b0;
      hpd_s3_q  <= 1'b0;
      rom_idx_q <= '0;
      dev_q     <= '0;
      reg_q     <= '0;
      dat_q     <= '0;
      fail_q    <= '0;
      req_q     <= 1'b0;
    end else begin
      start_q  <= Start;
      hpd_s1_q <= HPD;
      hpd_s2_q <= hpd_s1_q;
      hpd_s3_q <= hpd_s2_q;
      if (trig && busy) pend_q <= 1'b1;

      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (trig || pend_q) begin
            pend_q    <= 1'b0;
            idx_q     <= '0;
            rom_idx_q <= '0;
            rty_q     <= '0;
            fail_q    <= '0;
            state_q   <= S_FETCH;
          end
        end
        S_FETCH: state_q <= S_LOAD;
        S_LOAD: begin
          if (Rom_Data == 16'hFFFF) begin
            state_q <= S_DONE;
          end else begin
            reg_q   <= Rom_Data[15:8];
            dat_q   <= Rom_Data[7:0];
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          req_q   <= 1'b1;
          dev_q   <= DEV_ADDR;
          to_q    <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_ok || wait_fail) begin
            req_q <= 1'b0;
            gap_q <= '0;
            if (wait_ok) begin
              rty_q   <= '0;
              adv_q   <= 1'b1;
              state_q <= S_GAP;
            end else if (rty_q < RTY_W'(RETRY_MAX)) begin
              rty_q   <= rty_q + RTY_W'(1);
              adv_q   <= 1'b0;
              state_q <= S_GAP;
            end else begin
              fail_q  <= 8'(idx_q);
              state_q <= S_ERROR;
            end
          end else begin
            to_q <= to_q + TO_W'(1);
          end
        end
        S_GAP: begin
          if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
            if (!adv_q) begin
              state_q <= S_ISSUE;
            end else if (idx_d == IDX_W'(NUM_ENTRIES)) begin
              state_q <= S_DONE;
            end else begin
              idx_q     <= idx_d;
              rom_idx_q <= 8'(idx_d);
              state_q   <= S_FETCH;
            end
          end else begin
            gap_q <= gap_q + GAP_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign Rom_Index  = rom_idx_q;
  assign I2C_Req    = req_q;
  assign I2C_Dev    = dev_q;
  assign I2C_Reg    = reg_q;
  assign I2C_Data   = dat_q;
  assign Fail_Index = fail_q;
  assign Busy       = busy;
  assign Done       = (state_q == S_DONE);
  assign Error      = (state_q == S_ERROR);

endmodule

// File: tb/tb_adv_config_sequencer.sv
// Directed bench for adv_config_sequencer: ROM and I2C master models plus a linear
// sequence of runs (ack, full table, nack retries, timeout, HPD rerun, reset).
module tb_adv_config_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        hpd = 1'b0;
  logic [7:0]  rom_index;
  logic [15:0] rom_data = 16'h0000;
  logic        req;
  logic [7:0]  dev, regb, datb, fail_idx;
  logic        done_i = 1'b0;
  logic        nack_i = 1'b0;
  logic        busy, done, err;

  always #5 clk = ~clk;

  adv_config_sequencer #(
    .NUM_ENTRIES(4),
    .TIMEOUT(64)
  ) dut (
    .Clock(clk), .Reset_n(rst_n), .Start(start), .HPD(hpd),
    .Rom_Index(rom_index), .Rom_Data(rom_data),
    .I2C_Req(req), .I2C_Dev(dev), .I2C_Reg(regb), .I2C_Data(datb),
    .I2C_Done(done_i), .I2C_Nack(nack_i),
    .Busy(busy), .Done(done), .Error(err), .Fail_Index(fail_idx)
  );

  logic [15:0] rom [0:255];
  logic [7:0]  idx_prev = 8'h00;
  logic        respond = 1'b1;
  logic [7:0]  nack_reg = 8'h00;
  int          nack_limit = 0;
  int          nack_given = 0;
  logic [7:0]  log_reg [0:63];
  logic [7:0]  log_dat [0:63];
  logic [7:0]  log_dev [0:63];
  int          log_low [0:63];
  int          log_high [0:63];
  int          nw = 0;
  int          low_cnt = 0;
  int          high_cnt = 0;
  logic        req_prev = 1'b0;
  int          max_idx = 0;

  // ROM answers one cycle after the index moves; master acks on the 10th Req-high cycle.
  always @(negedge clk) begin
    rom_data = rom[idx_prev];
    idx_prev = rom_index;
    if (int'(rom_index) > max_idx) max_idx = int'(rom_index);
    done_i = 1'b0;
    nack_i = 1'b0;
    if (req === 1'b1) begin
      if (!req_prev) begin
        if (nw < 64) begin
          log_reg[nw] = regb;
          log_dat[nw] = datb;
          log_dev[nw] = dev;
          log_low[nw] = low_cnt;
        end
        nw++;
        high_cnt = 0;
      end
      high_cnt++;
      if (respond && high_cnt == 10) begin
        done_i = 1'b1;
        if (regb == nack_reg && nack_given < nack_limit) begin
          nack_i = 1'b1;
          nack_given++;
        end
      end
      low_cnt = 0;
    end else begin
      if (req_prev && nw > 0 && nw <= 64) log_high[nw-1] = high_cnt;
      low_cnt++;
    end
    req_prev = (req === 1'b1);
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int maxc);
    int c = 0;
    while (!(done || err) && c < maxc) begin
      @(negedge clk);
      c++;
    end
    chk({tag, "_bound"}, 32'(c < maxc), 32'd1);
  endtask

  task automatic wait_req(input string tag, input int maxc);
    int c = 0;
    while (req !== 1'b1 && c < maxc) begin
      @(negedge clk);
      c++;
    end
    chk({tag, "_bound"}, 32'(c < maxc), 32'd1);
  endtask

  logic [7:0] exp_reg [0:3];
  logic [7:0] exp_dat [0:3];
  int base;
  int c;

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    rom[0] = 16'h4110; rom[1] = 16'h9803; rom[2] = 16'hD6C0; rom[3] = 16'hFFFF;
    rom[4] = 16'h3C4D;
    exp_reg[0] = 8'h41; exp_reg[1] = 8'h98; exp_reg[2] = 8'hD6; exp_reg[3] = 8'h1A;
    exp_dat[0] = 8'h10; exp_dat[1] = 8'h03; exp_dat[2] = 8'hC0; exp_dat[3] = 8'h2B;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_req", req, 0);
    chk("rst_idx", rom_index, 0);
    chk("rst_dev", dev, 0);
    chk("rst_fail", fail_idx, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy", busy, 0);

    // Three writes, terminator at entry 3
    base = nw;
    pulse_start();
    chk("A_busy_run", busy, 1);
    wait_end("A", 2000);
    repeat (2) @(negedge clk);
    chk("A_writes", nw - base, 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("A_dev%0d", i), log_dev[base+i], 8'h72);
      chk($sformatf("A_reg%0d", i), log_reg[base+i], exp_reg[i]);
      chk($sformatf("A_dat%0d", i), log_dat[base+i], exp_dat[i]);
    end
    // GAP(4) + FETCH + LOAD + ISSUE between Req drop and next Req
    chk("A_gap1", log_low[base+1], 7);
    chk("A_gap2", log_low[base+2], 7);
    chk("A_high0", log_high[base], 10);
    chk("A_done", done, 1);
    chk("A_busy", busy, 0);
    chk("A_err", err, 0);
    chk("A_idx", rom_index, 3);

    // No terminator: NUM_ENTRIES bounds the run
    rom[3] = 16'h1A2B;
    base = nw;
    pulse_start();
    wait_end("B", 2000);
    repeat (2) @(negedge clk);
    chk("B_writes", nw - base, 4);
    chk("B_reg3", log_reg[base+3], 8'h1A);
    chk("B_dat3", log_dat[base+3], 8'h2B);
    chk("B_maxidx", max_idx, 3);
    chk("B_done", done, 1);
    chk("B_busy", busy, 0);

    // Master silent: timeout on every attempt of entry 0
    respond = 1'b0;
    base = nw;
    pulse_start();
    wait_end("D", 3000);
    repeat (2) @(negedge clk);
    chk("D_writes", nw - base, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("D_reg%0d", i), log_reg[base+i], 8'h41);
      chk($sformatf("D_high%0d", i), log_high[base+i], 64);
    end
    chk("D_retry_gap", log_low[base+1], 5);
    chk("D_err", err, 1);
    chk("D_done", done, 0);
    chk("D_busy", busy, 0);
    chk("D_fail", fail_idx, 0);
    respond = 1'b1;

    // HPD during write 2 queues a second run
    rom[3] = 16'hFFFF;
    base = nw;
    pulse_start();
    c = 0;
    while (!(nw >= base + 2 && req === 1'b1) && c < 1000) begin
      @(negedge clk);
      c++;
    end
    chk("E_w2_bound", 32'(c < 1000), 1);
    hpd = 1'b1;
    wait_end("E1", 2000);
    chk("E1_done", done, 1);
    @(negedge clk);
    chk("E_rerun_done", done, 0);
    chk("E_rerun_busy", busy, 1);
    wait_end("E2", 2000);
    repeat (2) @(negedge clk);
    chk("E_writes", nw - base, 6);
    chk("E_reg3", log_reg[base+3], 8'h41);
    chk("E_reg5", log_reg[base+5], 8'hD6);
    chk("E_done", done, 1);
    hpd = 1'b0;
    repeat (5) @(negedge clk);

    // Entry 1 nacked on every attempt
    nack_reg = 8'h98;
    nack_limit = nack_given + 4;
    base = nw;
    pulse_start();
    wait_end("C", 3000);
    repeat (2) @(negedge clk);
    chk("C_writes", nw - base, 5);
    chk("C_reg0", log_reg[base], 8'h41);
    for (int i = 1; i < 5; i++) chk($sformatf("C_reg%0d", i), log_reg[base+i], 8'h98);
    chk("C_retry_gap", log_low[base+2], 5);
    chk("C_err", err, 1);
    chk("C_fail", fail_idx, 1);
    chk("C_busy", busy, 0);
    repeat (3) @(negedge clk);
    chk("C_fail_hold", fail_idx, 1);

    // Reset while in ERROR
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    chk("R_err", err, 0);
    chk("R_fail", fail_idx, 0);
    @(negedge clk); rst_n = 1'b1;

    // Reset mid-write
    pulse_start();
    wait_req("F", 500);
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    chk("F_req", req, 0);
    chk("F_busy", busy, 0);
    chk("F_idx", rom_index, 0);
    chk("F_dev", dev, 0);
    chk("F_reg", regb, 0);
    chk("F_dat", datb, 0);
    @(negedge clk); rst_n = 1'b1;
    base = nw;
    repeat (20) @(negedge clk);
    chk("F_idle_busy", busy, 0);
    chk("F_idle_req", req, 0);
    chk("F_no_resume", nw - base, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
